// File: rtl/mem_pkg.sv
// Shared types and constants for the Memorie burst master.
package mem_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefLenWidth  = 4;
  localparam int unsigned DefRbufDepth = 4;

  localparam logic MEM_WRITE = 1'b1;
  localparam logic MEM_READ  = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain
  } state_e;

endpackage

// File: rtl/mem_burst_master_if.sv
// Host command, write stream, read stream and Memorie port bundle of the burst master.
interface mem_burst_master_if #(
  parameter int unsigned DinLENGTH = mem_pkg::DefDataWidth,
  parameter int unsigned WIDTH     = mem_pkg::DefAddrWidth,
  parameter int unsigned LEN_W     = mem_pkg::DefLenWidth
);

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_rw;
  logic [WIDTH-1:0]     cmd_addr;
  logic [LEN_W-1:0]     cmd_len;
  logic [DinLENGTH-1:0] wr_data;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [DinLENGTH-1:0] rd_data;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 mem_r_w;
  logic                 mem_valid;
  logic [WIDTH-1:0]     mem_addr;
  logic [DinLENGTH-1:0] mem_din;
  logic [DinLENGTH-1:0] mem_dout;
  logic                 busy;
  logic                 done;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_dout,
    output cmd_ready, wr_ready, rd_data, rd_valid, mem_r_w, mem_valid, mem_addr, mem_din,
           busy, done
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, mem_dout,
    input  cmd_ready, wr_ready, rd_data, rd_valid, mem_r_w, mem_valid, mem_addr, mem_din,
           busy, done
  );

endinterface

// File: rtl/rd_return_buf.sv
// Synchronous FIFO holding read returns; Depth must be a power of two.
module rd_return_buf #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] storage_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CntW'(Depth)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) storage_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = storage_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/mem_burst_master.sv
// Burst initiator for the Memorie port: one host command becomes a run of single-beat
// accesses, with write data streamed in and read returns streamed out via a return buffer.
module mem_burst_master
  import mem_pkg::*;
#(
  parameter int unsigned DinLENGTH  = DefDataWidth,
  parameter int unsigned WIDTH      = DefAddrWidth,
  parameter int unsigned LEN_W      = DefLenWidth,
  parameter int unsigned RBUF_DEPTH = DefRbufDepth
) (
  input logic                clk,
  input logic                reset,
  mem_burst_master_if.master bus
);

  localparam int unsigned CntW = $clog2(RBUF_DEPTH) + 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]     remaining_q, remaining_d;
  logic [CntW-1:0]      in_flight_q, in_flight_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_r_w_q, mem_r_w_d;
  logic [WIDTH-1:0]     mem_addr_q, mem_addr_d;
  logic [DinLENGTH-1:0] mem_din_q, mem_din_d;
  logic                 wr_done_q, wr_done_d;
  logic                 capture_q, capture_d;

  logic                 cmd_fire, credit_ok, issue, pop, drain_done, buf_empty;
  logic [CntW-1:0]      occupancy;
  logic [DinLENGTH-1:0] buf_head;

  assign cmd_fire  = bus.cmd_valid && cmd_ready_q;
  assign pop       = bus.rd_ready && !buf_empty;
  // Outstanding reads plus buffered data must fit the buffer, so returns never overflow it.
  assign credit_ok = ({1'b0, occupancy} + {1'b0, in_flight_q}) < (CntW + 1)'(RBUF_DEPTH);
  assign issue     = (state_q == StRead) && credit_ok;
  assign drain_done = (state_q == StDrain) && (in_flight_q == '0) &&
                      (occupancy == CntW'(1)) && pop;
  // Memorie dout is valid the cycle after a read access is presented.
  assign capture_d = mem_valid_q && (mem_r_w_q == MEM_READ);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    mem_valid_d = 1'b0;
    mem_r_w_d   = MEM_READ;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    wr_done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          cur_addr_d  = bus.cmd_addr;
          remaining_d = bus.cmd_len;
          state_d     = (bus.cmd_rw == MEM_WRITE) ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (bus.wr_valid) begin
          mem_valid_d = 1'b1;
          mem_r_w_d   = MEM_WRITE;
          mem_addr_d  = cur_addr_q;
          mem_din_d   = bus.wr_data;
          cur_addr_d  = cur_addr_q + WIDTH'(1);
          if (remaining_q == '0) begin
            state_d   = StIdle;
            wr_done_d = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
          end
        end
      end
      StRead: begin
        if (credit_ok) begin
          mem_valid_d = 1'b1;
          mem_addr_d  = cur_addr_q;
          cur_addr_d  = cur_addr_q + WIDTH'(1);
          if (remaining_q == '0) state_d = StDrain;
          else remaining_d = remaining_q - LEN_W'(1);
        end
      end
      StDrain: begin
        if (drain_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Re-arm only after a full cycle back in idle, keeping cmd_ready low while done pulses.
    cmd_ready_d = (state_q == StIdle) && (state_d == StIdle);

    case ({issue, capture_q})
      2'b10:   in_flight_d = in_flight_q + CntW'(1);
      2'b01:   in_flight_d = in_flight_q - CntW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      in_flight_q <= '0;
      cmd_ready_q <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_r_w_q   <= MEM_READ;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wr_done_q   <= 1'b0;
      capture_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      in_flight_q <= in_flight_d;
      cmd_ready_q <= cmd_ready_d;
      mem_valid_q <= mem_valid_d;
      mem_r_w_q   <= mem_r_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      wr_done_q   <= wr_done_d;
      capture_q   <= capture_d;
    end
  end

  rd_return_buf #(
    .Width (DinLENGTH),
    .Depth (RBUF_DEPTH)
  ) u_rd_return_buf (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (capture_q),
    .data_i  (bus.mem_dout),
    .pop_i   (pop),
    .data_o  (buf_head),
    .empty_o (buf_empty),
    .count_o (occupancy)
  );

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.wr_ready  = (state_q == StWrite);
  assign bus.rd_valid  = !buf_empty;
  assign bus.rd_data   = buf_head;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_r_w   = mem_r_w_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_din   = mem_din_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = wr_done_q | drain_done;

endmodule

// File: tb/tb_mem_burst_master.sv
// Bench for mem_burst_master: directed and random bursts against a Memorie model and
// a reference memory image that predicts every access and every read return.
module tb_mem_burst_master;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned LW = 4;
  localparam int unsigned RD = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_burst_master_if #(.DinLENGTH(DW), .WIDTH(AW), .LEN_W(LW)) bus ();

  mem_burst_master #(
    .DinLENGTH  (DW),
    .WIDTH      (AW),
    .LEN_W      (LW),
    .RBUF_DEPTH (RD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int          cyc;
  } acc_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int pres_rd = 0;
  int popped = 0;
  acc_t acc_q[$];
  logic [DW-1:0] rd_q[$];
  acc_t mon_acc;
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] mem_array [256];
  bit mem_loaded = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Memorie model: write on valid&&r_w, read data appears one cycle after presentation.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem_array[i] <= ref_mem[i];
      mem_loaded <= 1'b1;
    end else if (bus.mem_valid) begin
      if (bus.mem_r_w) mem_array[bus.mem_addr] <= bus.mem_din;
      else bus.mem_dout <= mem_array[bus.mem_addr];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pres_rd = 0;
      popped  = 0;
    end else begin
      if (bus.mem_valid) begin
        mon_acc.rw   = bus.mem_r_w;
        mon_acc.addr = bus.mem_addr;
        mon_acc.data = bus.mem_din;
        mon_acc.cyc  = cyc;
        acc_q.push_back(mon_acc);
        if (!bus.mem_r_w) begin
          pres_rd++;
          check("read_credit", 64'((pres_rd - popped) <= RD), 64'd1);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        rd_q.push_back(bus.rd_data);
        popped++;
      end
      if (bus.done) done_cnt++;
    end
  end

  task automatic wait_accept();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!bus.cmd_ready && n < 20);
    check("cmd_accept", bus.cmd_ready, 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // gap < 0 selects an alternating 1,0,1,0 write-valid pattern; hold >= 6 stalls reads.
  task automatic run_burst(input bit rw, input logic [AW-1:0] addr, input int len,
                           input logic [DW-1:0] base, input int gap, input int stall,
                           input int hold);
    logic [DW-1:0] wdata [16];
    logic [AW-1:0] a;
    int accept_cyc[$];
    int done0, idx, pops, cycles;
    bit seen_done;
    for (int i = 0; i < 16; i++) wdata[i] = (base != '0) ? base + DW'(i) : DW'($urandom);
    acc_q.delete();
    rd_q.delete();
    done0 = done_cnt;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_rw    = rw;
    bus.cmd_addr  = addr;
    bus.cmd_len   = LW'(len);
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;
    wait_accept();
    idx = 0; pops = 0; cycles = 0; seen_done = 1'b0;
    while (!seen_done && cycles < 400) begin
      if (rw) begin
        if (gap < 0) bus.wr_valid = (idx <= len) && (cycles % 2 == 0);
        else bus.wr_valid = (idx <= len) && (int'($urandom_range(99)) >= gap);
        bus.wr_data = wdata[idx % 16];
      end else begin
        bus.wr_valid = 1'($urandom_range(1));
        bus.wr_data  = DW'($urandom);
      end
      bus.rd_ready = (cycles >= hold) && (int'($urandom_range(99)) >= stall);
      @(negedge clk); #1;
      cycles++;
      if (cycles == 1) begin
        check("busy_active", bus.busy, 1);
        check("wr_ready_state", bus.wr_ready, 64'(rw));
      end
      if (hold > 0 && cycles == hold)
        check("stall_issue_count", 64'(acc_q.size()), 64'((len + 1 < RD) ? len + 1 : RD));
      if (bus.wr_valid && bus.wr_ready) begin
        accept_cyc.push_back(cyc);
        idx++;
      end
      if (bus.rd_valid && bus.rd_ready) pops++;
      if (bus.done) begin
        seen_done = 1'b1;
        check("done_cmd_ready_low", bus.cmd_ready, 0);
        if (rw) check("done_with_last_write", {bus.mem_valid, idx == len + 1}, 2'b11);
        else check("done_on_last_pop", {bus.rd_valid & bus.rd_ready, pops == len + 1}, 2'b11);
      end
      @(posedge clk); #1;
    end
    check("done_seen", seen_done, 1);
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    @(negedge clk); #1;
    check("done_one_cycle", bus.done, 0);
    check("busy_idle", bus.busy, 0);
    @(negedge clk); #1;
    check("cmd_ready_rearm", bus.cmd_ready, 1);
    check("done_count", 64'(done_cnt - done0), 64'd1);
    check("access_count", 64'(acc_q.size()), 64'(len + 1));
    for (int i = 0; i <= len; i++) begin
      a = AW'(int'(addr) + i);
      if (i < acc_q.size()) begin
        check("acc_addr", acc_q[i].addr, a);
        check("acc_rw", 64'(acc_q[i].rw), 64'(rw));
        if (rw) check("acc_wdata", acc_q[i].data, wdata[i]);
        if (rw && i < accept_cyc.size())
          check("acc_latency", 64'(acc_q[i].cyc), 64'(accept_cyc[i] + 1));
      end
      if (rw) ref_mem[a] = wdata[i];
    end
    if (!rw) begin
      check("read_beats", 64'(rd_q.size()), 64'(len + 1));
      for (int i = 0; i <= len; i++) begin
        a = AW'(int'(addr) + i);
        if (i < rd_q.size()) check("rd_data", rd_q[i], ref_mem[a]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops, cycles;
    bit rw_r;
    logic [AW-1:0] addr_r;
    int len_r, gap_r, stall_r, hold_r;
    bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.mem_valid,
                         bus.mem_r_w, bus.busy, bus.done}, 0);
    check("reset_bus", {bus.mem_addr, bus.mem_din}, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    check("idle_cmd_ready", {bus.cmd_ready, bus.busy}, 2'b10);

    run_burst(1'b1, 8'h10, 3, 32'hA0, 0, 0, 0);
    run_burst(1'b0, 8'h10, 3, '0, 0, 0, 0);
    run_burst(1'b0, 8'h10, 7, '0, 0, 0, 10);
    run_burst(1'b1, 8'hFE, 3, '0, 0, 0, 0);
    run_burst(1'b0, 8'hFE, 3, '0, 0, 0, 0);
    run_burst(1'b1, 8'h33, 1, '0, -1, 0, 0);
    run_burst(1'b1, 8'h70, 0, '0, 0, 0, 0);
    run_burst(1'b0, 8'h70, 0, '0, 50, 50, 0);

    // Reset during the second beat of a read abandons the burst without done.
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_rw = 1'b0; bus.cmd_addr = 8'h40; bus.cmd_len = 4'd7;
    bus.rd_ready = 1'b1;
    wait_accept();
    pops = 0; cycles = 0;
    while (pops < 1 && cycles < 50) begin
      @(negedge clk); #1;
      cycles++;
      if (bus.rd_valid && bus.rd_ready) pops++;
    end
    check("mid_read_first_pop", 64'(pops), 64'd1);
    @(posedge clk); #3;
    check("mid_read_busy_before", bus.busy, 1);
    reset = 1'b0;
    #1;
    check("mid_reset_ctrl", {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.mem_valid,
                             bus.mem_r_w, bus.busy, bus.done}, 0);
    check("mid_reset_bus", {bus.mem_addr, bus.mem_din}, 0);
    cycles = done_cnt;
    repeat (3) begin
      @(negedge clk); #1;
      check("mid_reset_no_done", {bus.done, bus.busy}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.rd_ready = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_reset_idle", {bus.done, bus.busy, bus.rd_valid}, 0);
    end
    check("mid_reset_done_count", 64'(done_cnt - cycles), 64'd0);
    run_burst(1'b1, 8'h40, 2, '0, 20, 0, 0);

    for (int n = 0; n < 12; n++) begin
      rw_r    = 1'($urandom_range(1));
      addr_r  = AW'($urandom);
      len_r   = int'($urandom_range(15));
      gap_r   = int'($urandom_range(60));
      stall_r = int'($urandom_range(70));
      hold_r  = (!rw_r && $urandom_range(2) == 0) ? 6 + int'($urandom_range(6)) : 0;
      run_burst(rw_r, addr_r, len_r, '0, gap_r, stall_r, hold_r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
